// File: rtl/lut_pkg.sv
// lut_pkg: shared types and constants for the LUT write-back stage.
// Holds the control FSM state encoding, datapath widths, the table-select
// mode code and the per-table entry counts.
package lut_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 128;

    localparam logic [2:0] MODE_SPN8 = 3'b000;

    localparam int N_SPN8  = 16;
    localparam int N_SPN16 = 8192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Index of the final entry of the table selected by mode.
    function automatic logic [ADDR_W-1:0] last_index(input logic [2:0] mode);
        if (mode == MODE_SPN8) begin
            return ADDR_W'(N_SPN8 - 1);
        end
        return ADDR_W'(N_SPN16 - 1);
    endfunction

endpackage

// File: rtl/lut_addr_fifo.sv
// lut_addr_fifo: small in-order FIFO holding the LUT address of every cipher
// request still in flight. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. A push on a full FIFO and a pop on an empty FIFO
// are ignored; a push and a pop in the same cycle are both honoured, with
// fullness judged before the pop.
module lut_addr_fifo
    import lut_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_addr = mem_q[rd_ptr_q];

    // Pointer and occupancy update for the accepted push/pop pair.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Address storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the occupancy
        // count guards every read, and a resettable array costs a mux per bit.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_addr;
        end
    end

endmodule

// File: rtl/lut_store.sv
// lut_store: write-back stage behind the LUT input generator.
// Paces the generator one entry per accepted cipher request, forwards the
// plaintext word to the cipher core, remembers each request's table address
// in an in-order FIFO and writes the returned cipher word into LUT RAM at
// that address one cycle after the result arrives. Pulses done once every
// entry of the selected table is written.
// Optional build macro: LUT_STORE_ERR_EN enables the sticky err flag for
// stray cipher results (result with no request outstanding, or in IDLE);
// without it err is tied low and stray results are silently dropped.
module lut_store
    import lut_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        alg_mode,
    input  logic [ADDR_W-1:0] addr_gen,
    input  logic [DATA_W-1:0] P_gen,
    input  logic              done_gen,
    output logic              gen_adv,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [DATA_W-1:0] enc_data,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    logic              issue_hs;
    logic              last_issue;

    // Request handshake, result acceptance and end-of-table detection. The
    // table ends on the generator's last entry or when the latched mode's
    // entry count is reached, whichever the generator presents first.
    assign issue_hs   = enc_valid && enc_ready;
    assign fifo_push  = issue_hs;
    assign fifo_pop   = res_valid && !fifo_empty;
    assign last_issue = issue_hs && (done_gen || (issue_cnt_q == last_index(mode_q)));

    assign enc_data  = P_gen;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    lut_addr_fifo #(
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (addr_gen),
        .pop       (fifo_pop),
        .head_addr (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. DRAIN leaves once the FIFO is empty: the final
    // write was registered on the pop and lands this cycle, so done follows it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs. enc_valid depends only on state and FIFO fullness, never
    // on enc_ready; the generator advances exactly on an accepted request.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        enc_valid = (state_q == ISSUE) && !fifo_full;
        gen_adv   = enc_valid && enc_ready;
    end

    // Datapath next values: mode latch, issue counter and the RAM write stage
    // that pairs each result with the FIFO head in effect when it arrived.
    always_comb begin
        mode_d      = mode_q;
        issue_cnt_d = issue_cnt_q;
        ram_we_d    = fifo_pop;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if ((state_q == IDLE) && start) begin
            mode_d      = alg_mode;
            issue_cnt_d = '0;
        end else if (issue_hs) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (fifo_pop) begin
            ram_addr_d  = fifo_head;
            ram_wdata_d = res_data;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= '0;
            issue_cnt_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            mode_q      <= mode_d;
            issue_cnt_q <= issue_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

`ifdef LUT_STORE_ERR_EN
    logic err_q, err_d;

    // Sticky protocol error: a result with nothing outstanding, or in IDLE.
    always_comb begin
        err_d = err_q;
        if (res_valid && (fifo_empty || (state_q == IDLE))) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_store.sv
// tb_lut_store: self-checking bench for lut_store. A generator model and a
// 2-cycle cipher model (P xor 0x5A..5A) surround the DUT; every accepted
// request pushes its expected RAM write into a scoreboard queue, and every
// ram_we pops and compares. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_lut_store;
    import lut_pkg::*;

    localparam logic [127:0] KEY = {16{8'h5A}};
`ifdef LUT_STORE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   alg_mode;
    logic [12:0]  addr_gen;
    logic [127:0] P_gen;
    logic         done_gen;
    logic         gen_adv;
    logic         enc_valid;
    logic         enc_ready;
    logic [127:0] enc_data;
    logic         res_valid;
    logic [127:0] res_data;
    logic         ram_we;
    logic [12:0]  ram_addr;
    logic [127:0] ram_wdata;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    lut_store #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .alg_mode(alg_mode),
        .addr_gen(addr_gen), .P_gen(P_gen), .done_gen(done_gen), .gen_adv(gen_adv),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
        .res_valid(res_valid), .res_data(res_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err)
    );

    typedef struct { logic [127:0] data; int due; } cres_t;
    typedef struct { logic [12:0] addr; logic [127:0] data; } wr_t;

    cres_t cq[$];
    wr_t   exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_hs = 0;
    int n_done = 0;
    int run_writes = 0;
    int run_expected = 0;
    int last_we_cyc = 0;
    int occ = 0;

    logic [12:0]  next_issue, first_waddr, last_waddr;
    logic [127:0] first_wdata, last_wdata;
    logic         nxt_rst, nxt_start, nxt_ready;
    logic [2:0]   nxt_mode;
    logic         stall, inject, s_gen_adv, s_res_ok;
    logic [127:0] inject_data;
    int           release_cnt;

    function automatic logic [127:0] pattern(input logic [12:0] a, input logic [2:0] m);
        logic [127:0] w;
        w = '0;
        if (m == 3'b000) begin
            for (int i = 0; i < 16; i++) w[127-8*i -: 8] = 8'(int'(a) * 16 + i);
        end else begin
            for (int i = 0; i < 8; i++) w[127-16*i -: 16] = 16'(int'(a) * 8 + i);
        end
        return w;
    endfunction

    function automatic logic [12:0] last_idx(input logic [2:0] m);
        return (m == 3'b000) ? 13'd15 : 13'd8191;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Falling-edge sampling: handshake bookkeeping, scoreboard and done checks.
    task automatic sample();
        logic hs;
        logic res_ok;
        wr_t  e;
        hs = enc_valid && enc_ready;
        check("gen_adv", gen_adv, hs);
        check("we_latency", ram_we, s_res_ok);
        res_ok = res_valid && (occ > 0);
        if (hs) begin
            check("issue_addr", addr_gen, next_issue);
            check("enc_data", enc_data, pattern(addr_gen, alg_mode));
            cq.push_back('{enc_data ^ KEY, cyc + 2});
            exp_q.push_back('{next_issue, pattern(next_issue, alg_mode) ^ KEY});
            next_issue = (next_issue == last_idx(alg_mode)) ? 13'd0 : next_issue + 13'd1;
            n_hs++;
        end
        occ = occ + (hs ? 1 : 0) - (res_ok ? 1 : 0);
        s_res_ok  = res_ok;
        s_gen_adv = gen_adv;
        if (ram_we) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ram_addr", ram_addr, e.addr);
                check("ram_wdata", ram_wdata, e.data);
            end
            if (run_writes == 0) begin
                first_waddr = ram_addr;
                first_wdata = ram_wdata;
            end
            last_waddr  = ram_addr;
            last_wdata  = ram_wdata;
            run_writes++;
            last_we_cyc = cyc;
        end
        if (done) begin
            n_done++;
            check("done_lag", cyc - last_we_cyc, 1);
            check("done_writes", run_writes, run_expected);
            check("done_sb_empty", exp_q.size(), 0);
            check("done_err", err, 0);
        end
    endtask

    // One clock: models update after the edge, then outputs are sampled.
    task automatic cycle();
        logic  rst_edge;
        cres_t c;
        @(posedge clk);
        rst_edge = rst;
        #1;
        cyc++;
        if (rst_edge) begin
            addr_gen   = '0;
            cq.delete();
            exp_q.delete();
            next_issue = '0;
            occ        = 0;
            s_res_ok   = 1'b0;
        end else if (s_gen_adv) begin
            addr_gen = (addr_gen == last_idx(alg_mode)) ? 13'd0 : addr_gen + 13'd1;
        end
        res_valid = 1'b0;
        res_data  = '0;
        if (inject) begin
            res_valid = 1'b1;
            res_data  = inject_data;
        end else if (cq.size() > 0 && cq[0].due <= cyc && (!stall || release_cnt > 0)) begin
            c = cq.pop_front();
            res_valid = 1'b1;
            res_data  = c.data;
            if (stall) release_cnt--;
        end
        rst       = nxt_rst;
        start     = nxt_start;
        enc_ready = nxt_ready;
        alg_mode  = nxt_mode;
        P_gen     = pattern(addr_gen, alg_mode);
        done_gen  = (addr_gen == last_idx(alg_mode));
        @(negedge clk);
        sample();
    endtask

    task automatic start_run(input logic [2:0] m);
        run_writes   = 0;
        run_expected = (m == 3'b000) ? N_SPN8 : N_SPN16;
        nxt_mode     = m;
        nxt_start    = 1'b1;
        cycle();
        nxt_start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input logic [12:0] target, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (addr_gen == target && enc_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        int   base_done;
        int   base_hs;
        rst = 1'b1; start = 1'b0; alg_mode = 3'b000; addr_gen = '0;
        P_gen = pattern(13'd0, 3'b000); done_gen = 1'b0; enc_ready = 1'b1;
        res_valid = 1'b0; res_data = '0;
        nxt_rst = 1'b1; nxt_start = 1'b0; nxt_ready = 1'b1; nxt_mode = 3'b000;
        stall = 1'b0; release_cnt = 0; inject = 1'b0; inject_data = '0;
        s_gen_adv = 1'b0; s_res_ok = 1'b0; next_issue = '0;
        first_waddr = '0; last_waddr = '0; first_wdata = '0; last_wdata = '0;

        // Reset state.
        repeat (3) cycle();
        check("rst_gen_adv", gen_adv, 0);
        check("rst_enc_valid", enc_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        nxt_rst = 1'b0;
        cycle();

        // Small table with a 3-cycle enc_ready gap at address 5.
        base_done = n_done;
        start_run(3'b000);
        wait_addr(13'd4, 40, seen);
        check("t1_reach_4", seen, 1);
        nxt_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("gap_gen_adv", gen_adv, 0);
            check("gap_addr_hold", addr_gen, 5);
        end
        nxt_ready = 1'b1;
        wait_done(100, seen);
        check("t1_done_seen", seen, 1);
        check("t1_busy_at_done", busy, 1);
        check("t1_first_addr", first_waddr, 0);
        check("t1_first_data", first_wdata, 128'h5A5B58595E5F5C5D5253505156575455);
        check("t1_last_addr", last_waddr, 15);
        cycle();
        check("t1_busy_after", busy, 0);
        repeat (3) cycle();
        check("t1_done_once", n_done - base_done, 1);

        // Stalled cipher results: FIFO depth bounds the requests in flight.
        stall = 1'b1;
        base_hs = n_hs;
        base_done = n_done;
        start_run(3'b000);
        repeat (12) cycle();
        check("stall_issues", n_hs - base_hs, 4);
        check("stall_enc_valid", enc_valid, 0);
        release_cnt = 1;
        repeat (6) cycle();
        check("release_issues", n_hs - base_hs, 5);
        check("release_enc_valid", enc_valid, 0);
        stall = 1'b0;
        wait_done(100, seen);
        check("t2_done_seen", seen, 1);
        repeat (3) cycle();
        check("t2_done_once", n_done - base_done, 1);

        // Full 8192-entry table.
        start_run(3'b001);
        wait_done(9000, seen);
        check("t3_done_seen", seen, 1);
        check("t3_last_addr", last_waddr, 8191);
        check("t3_last_data", last_wdata, 128'hA5A2A5A3A5A0A5A1A5A6A5A7A5A4A5A5);
        check("t3_busy_at_done", busy, 1);
        cycle();
        check("t3_busy_after", busy, 0);
        check("t3_done_low", done, 0);

        // Reset while entry 7 is presented, then rebuild from address 0.
        start_run(3'b000);
        wait_addr(13'd6, 40, seen);
        check("t4_reach_6", seen, 1);
        nxt_rst = 1'b1;
        cycle();
        nxt_rst = 1'b0;
        cycle();
        check("mid_rst_gen_adv", gen_adv, 0);
        check("mid_rst_enc_valid", enc_valid, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ram_addr", ram_addr, 0);
        check("mid_rst_ram_wdata", ram_wdata, 0);
        base_done = n_done;
        start_run(3'b000);
        wait_done(100, seen);
        check("t4_done_seen", seen, 1);
        check("t4_first_addr", first_waddr, 0);
        check("t4_last_addr", last_waddr, 15);
        repeat (3) cycle();
        check("t4_done_once", n_done - base_done, 1);

        // Stray result in IDLE.
        inject_data = 128'h0123456789ABCDEF0123456789ABCDEF;
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        cycle();
        check("stray_no_we", ram_we, 0);
        check("stray_err", err, ERR_EXP);
        repeat (3) cycle();
        check("err_sticky", err, ERR_EXP);
        check("stray_still_no_we", ram_we, 0);
        nxt_rst = 1'b1;
        cycle();
        nxt_rst = 1'b0;
        cycle();
        check("err_cleared", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
